// File: rtl/lcd_nibble_rx.sv
// 4-bit HD44780-style bus receiver: rebuilds bytes from two nibbles latched on
// falling LCD_E and queues them, with their RS bit, in a small FWFT FIFO.
module lcd_nibble_rx #(
  parameter int TIMEOUT = 1023,
  parameter int DEPTH   = 4
) (
  input  logic       HCLK,
  input  logic       HRESETn,
  input  logic       LCD_RS,
  input  logic       LCD_RW,
  input  logic       LCD_E,
  input  logic [3:0] LCD_DB,
  output logic [7:0] rx_data,
  output logic       rx_is_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  input  logic       err_clr,
  output logic       overflow,
  output logic       frame_err,
  output logic       busy
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [AW:0]      PTR_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  typedef enum logic {PH_HIGH, PH_LOW} phase_t;

  logic [6:0]       sync_p0, sync_p1;
  logic             e_prev_p2;
  logic             rs_s, rw_s, e_s;
  logic [3:0]       db_s;
  logic             fall, wr_edge;
  phase_t           phase;
  logic [CNT_W-1:0] idle_cnt;
  logic [3:0]       hi_nib;
  logic             hi_rs;
  logic             push, frame_set;
  logic [8:0]       mem [DEPTH];
  logic [AW:0]      wptr, rptr;
  logic             full, pop, wr_en, drop;
  logic [8:0]       head;

  // Stage p0/p1: two-flop synchronizer on every bus signal; p2: E history
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      sync_p0   <= '0;
      sync_p1   <= '0;
      e_prev_p2 <= 1'b0;
    end else begin
      sync_p0   <= {LCD_RS, LCD_RW, LCD_E, LCD_DB};
      sync_p1   <= sync_p0;
      e_prev_p2 <= sync_p1[4];
    end
  end

  assign rs_s    = sync_p1[6];
  assign rw_s    = sync_p1[5];
  assign e_s     = sync_p1[4];
  assign db_s    = sync_p1[3:0];
  assign fall    = ~e_s & e_prev_p2;
  assign wr_edge = fall & ~rw_s;

  assign push      = (phase == PH_LOW) && wr_edge && (rs_s == hi_rs);
  assign frame_set = (phase == PH_LOW) && wr_edge && (rs_s != hi_rs);

  // Nibble phase and inactivity timeout
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      phase    <= PH_HIGH;
      idle_cnt <= '0;
    end else begin
      case (phase)
        PH_HIGH: begin
          idle_cnt <= '0;
          if (wr_edge) phase <= PH_LOW;
        end
        PH_LOW: begin
          if (fall) begin
            idle_cnt <= '0;
            if (wr_edge) phase <= PH_HIGH;
          end else if (idle_cnt == CNT_MAX) begin
            idle_cnt <= '0;
            phase    <= PH_HIGH;
          end else begin
            idle_cnt <= idle_cnt + CNT_ONE;
          end
        end
        default: begin
          phase    <= PH_HIGH;
          idle_cnt <= '0;
        end
      endcase
    end
  end

  // Held high nibble is only read in PH_LOW, which always follows a write here
  always_ff @(posedge HCLK) begin
    if ((phase == PH_HIGH) && wr_edge) begin
      hi_nib <= db_s;
      hi_rs  <= rs_s;
    end
  end

  assign busy = (phase == PH_LOW);

  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign pop   = rx_valid & rx_ready;
  assign wr_en = push & (~full | pop);
  assign drop  = push & full & ~pop;

  always_ff @(posedge HCLK) begin
    if (wr_en) mem[wptr[AW-1:0]] <= {rs_s, hi_nib, db_s};
  end

  // FIFO pointers and sticky error flags; a set beats a same-cycle clear
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wptr      <= '0;
      rptr      <= '0;
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (wr_en) wptr <= wptr + PTR_ONE;
      if (pop)   rptr <= rptr + PTR_ONE;
      if (drop)         overflow <= 1'b1;
      else if (err_clr) overflow <= 1'b0;
      if (frame_set)    frame_err <= 1'b1;
      else if (err_clr) frame_err <= 1'b0;
    end
  end

  assign rx_valid   = (wptr != rptr);
  assign head       = mem[rptr[AW-1:0]];
  assign rx_data    = rx_valid ? head[7:0] : 8'h00;
  assign rx_is_data = rx_valid ? head[8] : 1'b0;

endmodule

// File: doc/lcd_nibble_rx.md
LCD_NIBBLE_RX -- requirements
Module: lcd_nibble_rx

Interface
REQ-001 SHALL have parameter TIMEOUT, default 1023: number of HCLK cycles of LCD_E inactivity after which a half-received byte is discarded.
REQ-002 SHALL have parameter DEPTH, default 4: receive FIFO depth in bytes, a power of two.
REQ-003 SHALL have port HCLK, input, 1: sole clock; all logic samples on the rising edge.
REQ-004 SHALL have port HRESETn, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port LCD_RS, input, 1: register select from the host (0 = command, 1 = data).
REQ-006 SHALL have port LCD_RW, input, 1: read/write from the host (0 = write).
REQ-007 SHALL have port LCD_E, input, 1: enable strobe; a nibble is latched on its falling edge.
REQ-008 SHALL have port LCD_DB, input, 4: data nibble, high nibble first.
REQ-009 SHALL have port rx_data, output, 8: byte at the FIFO head.
REQ-010 SHALL have port rx_is_data, output, 1: RS of the byte at the FIFO head.
REQ-011 SHALL have port rx_valid, output, 1: FIFO non-empty.
REQ-012 SHALL have port rx_ready, input, 1: consumer accepts the head byte; a pop occurs when rx_valid and rx_ready are both 1.
REQ-013 SHALL have port err_clr, input, 1: single-cycle pulse that clears overflow and frame_err.
REQ-014 SHALL have port overflow, output, 1: sticky flag; a byte was dropped because the FIFO was full.
REQ-015 SHALL have port frame_err, output, 1: sticky flag; RS changed between the two nibbles of a byte.
REQ-016 SHALL have port busy, output, 1: high nibble held, low nibble awaited.

Function
REQ-017 SHALL pass LCD_RS, LCD_RW, LCD_E and LCD_DB through a 2-flop synchronizer before any use.
REQ-018 SHALL detect a falling edge when the synchronized E is 0 and its previous registered value is 1.
REQ-019 SHALL, on each falling edge, sample the synchronized DB, RS and RW in the same cycle.
REQ-020 SHALL ignore any edge whose sampled RW is 1: no nibble is captured and the phase is unchanged.
REQ-021 Phase SHALL be a 2-state machine, HIGH and LOW. HIGH + write edge: store nibble as bits[7:4], store RS, go to LOW.
REQ-022 LOW + write edge with RS equal to the stored RS: form byte {stored, DB}, push it with RS, return to HIGH.
REQ-023 LOW + write edge with RS differing from the stored RS: set frame_err, push nothing, return to HIGH.
REQ-024 SHALL keep an inactivity counter that is cleared on every falling edge and increments while in LOW.
REQ-025 SHALL return from LOW to HIGH without pushing when the inactivity counter reaches TIMEOUT.
REQ-026 busy SHALL equal (phase == LOW).
REQ-027 The FIFO SHALL be first-word-fall-through, with rx_data and rx_is_data valid whenever rx_valid is 1.
REQ-028 A push SHALL make rx_valid 1 at the third rising HCLK edge after the first edge that samples LCD_E low, provided the FIFO was empty.
REQ-029 A push into a full FIFO with no pop in the same cycle SHALL drop the byte and set overflow.
REQ-030 A push and a pop in the same cycle SHALL both succeed regardless of fill level, with no overflow.
REQ-031 Pointers SHALL use log2(DEPTH)+1 bits and wrap modulo 2*DEPTH; full and empty SHALL be derived from the MSB/equality compare.
REQ-032 err_clr SHALL clear both flags; a set condition in the same cycle as err_clr SHALL win.

Reset
REQ-033 HRESETn low SHALL immediately clear the synchronizers, phase (to HIGH), inactivity counter, FIFO pointers, overflow and frame_err.
REQ-034 During reset, rx_valid, busy, overflow and frame_err SHALL be 0, and rx_data and rx_is_data SHALL be 0.
REQ-035 A reset asserted mid-byte SHALL discard the held nibble; the next edge after reset SHALL be treated as a high nibble.

Verification
REQ-036 Send cmd 0x28 (RS=0, nibbles 2 then 8, E pulses of 51 cycles) -> rx_data=0x28, rx_is_data=0, rx_valid 3 edges after E low.
REQ-037 Send data 0x41 (RS=1) with rx_ready=1 -> one pop of 0x41/1; rx_valid then returns to 0; busy is 1 only between the nibbles.
REQ-038 Send 5 bytes 0x10..0x14 with rx_ready=0 -> FIFO holds 0x10..0x13, overflow=1; draining yields exactly those 4 bytes in order.
REQ-039 Send a high nibble with RS=0, then a low nibble with RS=1 -> frame_err=1, no push; err_clr pulse -> frame_err=0.
REQ-040 Send a single nibble 0x5, idle 1100 cycles, then byte 0x55 -> exactly one byte 0x55 received, with busy=0 after the timeout.
REQ-041 Edges with RW=1 interleaved between the nibbles of 0x3C -> 0x3C received intact; assert HRESETn mid-byte -> no push, busy=0.
